// File: rtl/memory_regfile_param.sv
// Parametrised register file: byte-masked write port, two registered read ports, sequenced clear-all sweep.
// Define WR_BYPASS_EN to forward a committing write onto a same-cycle read of that entry.
module memory_regfile_param #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_i,
   input  logic [ADDR_W-1:0]    waddr_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic [WIDTH/8-1:0]   wbe_i,
   input  logic [ADDR_W-1:0]    raddr0_i,
   output logic [WIDTH-1:0]     rdata0_o,
   input  logic [ADDR_W-1:0]    raddr1_i,
   output logic [WIDTH-1:0]     rdata1_o,
   input  logic                 clr_req_i,
   output logic                 busy_o,
   output logic                 clr_done_o
);

   localparam int unsigned NBYTES = WIDTH / 8;
   localparam int unsigned AW1    = ADDR_W + 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  rdata0_q, rdata0_d;
   logic [WIDTH-1:0]  rdata1_q, rdata1_d;

   logic              wr_commit_c;
   logic [WIDTH-1:0]  wr_old_c;
   logic [WIDTH-1:0]  wr_merged_c;

   // Extra bit keeps the compare meaningful when DEPTH == 2**ADDR_W.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < AW1'(DEPTH);
   endfunction

   // Byte-merged write value and commit qualifier (writes are dropped while sweeping).
   always_comb begin
      wr_old_c = '0;
      if (in_range(waddr_i)) begin
         wr_old_c = mem_q[waddr_i];
      end
      wr_merged_c = wr_old_c;
      for (int unsigned b = 0; b < NBYTES; b++) begin
         if (wbe_i[b]) begin
            wr_merged_c[8*b +: 8] = wdata_i[8*b +: 8];
         end
      end
      wr_commit_c = we_i && (state_q == ST_IDLE) && in_range(waddr_i) && (|wbe_i);
   end

   // Read ports; out-of-range addresses return zero.
   always_comb begin
      rdata0_d = '0;
      rdata1_d = '0;
      if (in_range(raddr0_i)) begin
         rdata0_d = mem_q[raddr0_i];
      end
      if (in_range(raddr1_i)) begin
         rdata1_d = mem_q[raddr1_i];
      end
`ifdef WR_BYPASS_EN
      if (wr_commit_c && (raddr0_i == waddr_i)) begin
         rdata0_d = wr_merged_c;
      end
      if (wr_commit_c && (raddr1_i == waddr_i)) begin
         rdata1_d = wr_merged_c;
      end
`endif
   end

   // Clear sweep sequencing.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req_i) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_CLEAR);
      done_d = (state_d == ST_CLEAR) && (ptr_d == ADDR_W'(DEPTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Storage: reset clears everything, the sweep has priority over the write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (state_q == ST_CLEAR) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_commit_c) begin
         mem_q[waddr_i] <= wr_merged_c;
      end
   end

   assign rdata0_o   = rdata0_q;
   assign rdata1_o   = rdata1_q;
   assign busy_o     = busy_q;
   assign clr_done_o = done_q;

endmodule

// File: tb/tb_memory_regfile_param.sv
// Self-checking bench for memory_regfile_param: directed scenarios plus random traffic
// against a cycle-level array model of the register file and clear sweep.
module tb_memory_regfile_param;

   localparam int D = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic [1:0]  wbe;
   logic [3:0]  raddr0;
   logic [15:0] rdata0;
   logic [3:0]  raddr1;
   logic [15:0] rdata1;
   logic        clr_req;
   logic        busy;
   logic        clr_done;

   always #5 clk = ~clk;

   memory_regfile_param #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
      .raddr0_i(raddr0), .rdata0_o(rdata0),
      .raddr1_i(raddr1), .rdata1_o(rdata1),
      .clr_req_i(clr_req), .busy_o(busy), .clr_done_o(clr_done)
   );

   int checks = 0;
   int errors = 0;

   // Reference: entry array plus count of sweep cycles still to run.
   logic [15:0] model_mem [D];
   int          clr_left = 0;
   logic [15:0] exp_rd0 = '0, exp_rd1 = '0;
   logic        exp_busy = 1'b0, exp_done = 1'b0;

   task automatic cycle();
      logic [15:0] merged, rd0, rd1;
      logic        commit;
      if (rst) begin
         for (int i = 0; i < D; i++) model_mem[i] = '0;
         clr_left = 0;
         rd0 = '0;
         rd1 = '0;
      end else begin
         commit = we && (clr_left == 0);
         merged = model_mem[waddr];
         for (int b = 0; b < 2; b++) if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
         rd0 = model_mem[raddr0];
         rd1 = model_mem[raddr1];
`ifdef WR_BYPASS_EN
         if (commit && waddr == raddr0) rd0 = merged;
         if (commit && waddr == raddr1) rd1 = merged;
`endif
         if (clr_left > 0) begin
            model_mem[D - clr_left] = '0;
            clr_left--;
         end else begin
            if (commit) model_mem[waddr] = merged;
            if (clr_req) clr_left = D;
         end
      end
      @(posedge clk);
      #1;
      exp_rd0  = rd0;
      exp_rd1  = rd1;
      exp_busy = (clr_left > 0);
      exp_done = (clr_left == 1);
   endtask

   task automatic quiet();
      rst = 1'b0; we = 1'b0; clr_req = 1'b0; wbe = 2'b00;
   endtask

   task automatic fill_random();
      for (int i = 0; i < D; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = 16'($urandom); wbe = 2'b11;
         cycle();
      end
      we = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 10; i++) begin
         we = 1'b1; waddr = 4'($urandom); wdata = 16'($urandom); wbe = 2'b11;
         cycle();
      end
      we = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", clr_done); end
      if (rdata0 !== 16'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0000", rdata0); end
      if (rdata1 !== 16'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0000", rdata1); end
      for (int i = 0; i < D; i++) begin
         raddr0 = 4'(i); raddr1 = 4'(D - 1 - i);
         cycle();
         checks += 2;
         if (rdata0 !== 16'h0) begin errors++; $display("FAIL reset_entry0[%0d]: got %h expected 0000", i, rdata0); end
         if (rdata1 !== 16'h0) begin errors++; $display("FAIL reset_entry1[%0d]: got %h expected 0000", D - 1 - i, rdata1); end
      end
   endtask

   task automatic test_full_write();
      we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; wbe = 2'b11;
      cycle();
      we = 1'b0; raddr0 = 4'd3;
      cycle();
      checks++;
      if (rdata0 !== 16'hBEEF) begin errors++; $display("FAIL full_write: got %h expected beef", rdata0); end
   endtask

   task automatic test_byte_mask();
      we = 1'b1; waddr = 4'd5; wdata = 16'h1234; wbe = 2'b11;
      cycle();
      wdata = 16'hABCD; wbe = 2'b01;
      cycle();
      we = 1'b0; raddr0 = 4'd5;
      cycle();
      checks++;
      if (rdata0 !== 16'h12CD) begin errors++; $display("FAIL byte_mask_low: got %h expected 12cd", rdata0); end
      we = 1'b1; wdata = 16'hFFFF; wbe = 2'b00;
      cycle();
      we = 1'b0;
      cycle();
      checks++;
      if (rdata0 !== 16'h12CD) begin errors++; $display("FAIL byte_mask_none: got %h expected 12cd", rdata0); end
   endtask

   task automatic test_read_during_write();
      logic [15:0] want;
      we = 1'b1; waddr = 4'd7; wdata = 16'hAAAA; wbe = 2'b11;
      cycle();
      wdata = 16'h5555; raddr1 = 4'd7;
      cycle();
      we = 1'b0;
`ifdef WR_BYPASS_EN
      want = 16'h5555;
`else
      want = 16'hAAAA;
`endif
      checks++;
      if (rdata1 !== want) begin errors++; $display("FAIL rdw_same_cycle: got %h expected %h", rdata1, want); end
      cycle();
      checks++;
      if (rdata1 !== 16'h5555) begin errors++; $display("FAIL rdw_after: got %h expected 5555", rdata1); end
   endtask

   // Counts busy cycles after a clr_req pulse, with a write attempted on entry 0 mid-sweep.
   task automatic run_sweep(input string tag);
      int n, done_at;
      n = 0; done_at = 0;
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy !== 1'b1) break;
         n++;
         checks++;
         if (clr_done !== exp_done) begin errors++; $display("FAIL %s_done_c%0d: got %b expected %b", tag, n, clr_done, exp_done); end
         if (clr_done === 1'b1) done_at = n;
         if (n == 3) begin we = 1'b1; waddr = 4'd0; wdata = 16'hDEAD; wbe = 2'b11; end
         else we = 1'b0;
         cycle();
      end
      we = 1'b0;
      checks += 3;
      if (n != D) begin errors++; $display("FAIL %s_busy_len: got %0d expected %0d", tag, n, D); end
      if (done_at != D) begin errors++; $display("FAIL %s_done_at: got %0d expected %0d", tag, done_at, D); end
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b expected 0", tag, busy); end
      for (int i = 0; i < D; i++) begin
         raddr0 = 4'(i); raddr1 = 4'(i);
         cycle();
         checks += 2;
         if (rdata0 !== 16'h0) begin errors++; $display("FAIL %s_entry0[%0d]: got %h expected 0000", tag, i, rdata0); end
         if (rdata1 !== exp_rd1) begin errors++; $display("FAIL %s_entry1[%0d]: got %h expected %h", tag, i, rdata1, exp_rd1); end
      end
   endtask

   task automatic test_clear();
      fill_random();
      run_sweep("clear");
   endtask

   task automatic test_reset_mid_sweep();
      fill_random();
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      for (int i = 0; i < D; i++) begin
         raddr0 = 4'(i);
         cycle();
         checks++;
         if (rdata0 !== 16'h0) begin errors++; $display("FAIL midrst_entry[%0d]: got %h expected 0000", i, rdata0); end
      end
      fill_random();
      run_sweep("restart");
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 149) == 0);
         we      = $urandom_range(0, 1) == 1;
         waddr   = 4'($urandom);
         wdata   = 16'($urandom);
         wbe     = 2'($urandom);
         raddr0  = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
         raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
         clr_req = ($urandom_range(0, 39) == 0);
         cycle();
         checks += 4;
         if (rdata0 !== exp_rd0) begin errors++; $display("FAIL rand_rdata0 @%0d: got %h expected %h", i, rdata0, exp_rd0); end
         if (rdata1 !== exp_rd1) begin errors++; $display("FAIL rand_rdata1 @%0d: got %h expected %h", i, rdata1, exp_rd1); end
         if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy @%0d: got %b expected %b", i, busy, exp_busy); end
         if (clr_done !== exp_done) begin errors++; $display("FAIL rand_done @%0d: got %b expected %b", i, clr_done, exp_done); end
      end
      quiet();
      for (int i = 0; i < D + 2; i++) cycle();
   endtask

   initial begin
      quiet();
      waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      test_reset();
      test_full_write();
      test_byte_mask();
      test_read_during_write();
      test_clear();
      test_reset_mid_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
